// File: rtl/demux_pkg.sv
// demux_pkg: shared constants and types for the 2048-entry write demux.
//   ADDR_W : write address width (11 bits, 2048 entries)
//   GR     : number of 1024-entry banks (groups)
//   M      : entries per bank
//   S      : address bits used for group select
//   DATA_W : entry width the stage-1 register is built for
// Optional feature macro: DEMUX_BE_EN adds per-byte write enables to the
// stage-1 register.
package demux_pkg;

    localparam int ADDR_W = 11;
    localparam int GR     = 2;
    localparam int M      = 1024;
    localparam int S      = 1;
    localparam int IDX_W  = ADDR_W - S;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } state_e;

    // Stage-1 (accepted write) register contents.
    typedef struct packed {
        logic                valid;
        logic [ADDR_W-1:0]   addr;
        logic [DATA_W-1:0]   data;
`ifdef DEMUX_BE_EN
        logic [DATA_W/8-1:0] be;
`endif
    } s1_t;

endpackage

// File: rtl/demux1024_wr_n.sv
// demux1024_wr_n: one 1024-entry storage bank with one-hot write decode and
// a single-entry clear port.
//   clk_i, rst_ni  : clock, async active-low reset (zeroes every entry)
//   we_i           : write this bank at addr_i on the next rising edge
//   addr_i         : entry index within the bank
//   data_i         : write data
//   be_i           : byte enables (only with DEMUX_BE_EN)
//   clr_i          : zero entry clr_idx_i on the next rising edge
//   clr_idx_i      : entry index to clear
//   data_o         : all 1024 entries
module demux1024_wr_n
    import demux_pkg::*;
#(
    parameter int n = DATA_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we_i,
    input  logic [IDX_W-1:0] addr_i,
    input  logic [n-1:0]     data_i,
`ifdef DEMUX_BE_EN
    input  logic [n/8-1:0]   be_i,
`endif
    input  logic             clr_i,
    input  logic [IDX_W-1:0] clr_idx_i,
    output logic [n-1:0]     data_o [0:M-1]
);

    logic [M-1:0] sel;
    logic [n-1:0] wmask;
    logic [n-1:0] mem_d [0:M-1];
    logic [n-1:0] mem_q [0:M-1];

    always_comb begin
        // One-hot entry select, gated by the bank write enable.
        sel         = '0;
        sel[addr_i] = we_i;

`ifdef DEMUX_BE_EN
        wmask = '0;
        for (int b = 0; b < n / 8; b++) begin
            wmask[b*8 +: 8] = {8{be_i[b]}};
        end
`else
        wmask = '1;
`endif

        for (int j = 0; j < M; j++) begin
            mem_d[j] = mem_q[j];
            if (sel[j]) begin
                mem_d[j] = (mem_q[j] & ~wmask) | (data_i & wmask);
            end
            // Clear zeroes the whole entry regardless of byte enables.
            if (clr_i && (clr_idx_i == IDX_W'(j))) begin
                mem_d[j] = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int j = 0; j < M; j++) begin
                mem_q[j] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign data_o = mem_q;

endmodule

// File: rtl/demux1to2048_wr_n.sv
// demux1to2048_wr_n: 2048-entry write demux with valid/ready write port and
// sequential bulk clear; all entries are exposed for the 2048:1 read mux.
//   clk_i, rst_ni : clock, async active-low reset
//   wr_valid_i/wr_ready_o/wr_addr_i/wr_data_i : write request port
//   wr_be_i       : byte enables (only with DEMUX_BE_EN)
//   clr_i         : bulk-clear request
//   busy_o        : write in flight or clear in progress
//   data_o        : all entries, data_o[g*M+j] = bank g entry j
//   dbg_state_o   : current control state (demux_pkg::state_e encoding)
// Handshake: a write is accepted on a rising edge where wr_valid_i and
// wr_ready_o are both high; wr_ready_o is a function of state and clr_i only,
// never of wr_valid_i. The accepted write lands in storage one edge later.
// Optional feature macro: DEMUX_BE_EN.
module demux1to2048_wr_n
    import demux_pkg::*;
#(
    parameter int n       = DATA_W,
    parameter int address = ADDR_W
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               wr_valid_i,
    output logic               wr_ready_o,
    input  logic [address-1:0] wr_addr_i,
    input  logic [n-1:0]       wr_data_i,
`ifdef DEMUX_BE_EN
    input  logic [n/8-1:0]     wr_be_i,
`endif
    input  logic               clr_i,
    output logic               busy_o,
    output logic [n-1:0]       data_o [0:GR*M-1],
    output logic [1:0]         dbg_state_o
);

    if (n != DATA_W) begin : g_n_check
        $error("demux1to2048_wr_n: n must equal demux_pkg::DATA_W");
    end
    if (address != ADDR_W) begin : g_addr_check
        $error("demux1to2048_wr_n: address must be 11");
    end
`ifdef DEMUX_BE_EN
    if ((n % 8) != 0) begin : g_be_check
        $error("demux1to2048_wr_n: n must be a multiple of 8 with byte enables");
    end
`endif

    state_e           state_d, state_q;
    logic [IDX_W-1:0] idx_d, idx_q;
    s1_t              s1_d, s1_q;
    logic             accept;

    always_comb begin
        wr_ready_o = (state_q == IDLE) && !clr_i;
        accept     = wr_valid_i && wr_ready_o;

        s1_d       = s1_q;
        s1_d.valid = accept;
        if (accept) begin
            s1_d.addr = wr_addr_i;
            s1_d.data = wr_data_i;
`ifdef DEMUX_BE_EN
            s1_d.be   = wr_be_i;
`endif
        end

        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (clr_i) begin
                    idx_d   = '0;
                    // A pending stage-1 write lands during DRAIN before the sweep.
                    state_d = s1_q.valid ? DRAIN : CLEAR;
                end
            end
            DRAIN: state_d = CLEAR;
            CLEAR: begin
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(M - 1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
            s1_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            s1_q    <= s1_d;
        end
    end

    assign busy_o      = s1_q.valid || (state_q != IDLE);
    assign dbg_state_o = state_q;

    for (genvar g = 0; g < GR; g++) begin : g_bank
        logic [n-1:0] bank_q [0:M-1];

        demux1024_wr_n #(.n(n)) u_bank (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .we_i      (s1_q.valid && (s1_q.addr[ADDR_W-1] == 1'(g))),
            .addr_i    (s1_q.addr[IDX_W-1:0]),
            .data_i    (s1_q.data),
`ifdef DEMUX_BE_EN
            .be_i      (s1_q.be),
`endif
            .clr_i     (state_q == CLEAR),
            .clr_idx_i (idx_q),
            .data_o    (bank_q)
        );

        for (genvar j = 0; j < M; j++) begin : g_map
            assign data_o[g*M + j] = bank_q[j];
        end
    end

endmodule

// File: tb/tb_demux1to2048_wr_n.sv
// tb_demux1to2048_wr_n: self-checking bench for demux1to2048_wr_n.
// Drivers issue writes and push the expected entry value (from a plain
// 2048-entry array model) into exp_q; a monitor pops and compares each one
// when the written value is due on data_o. Optional macro: DEMUX_BE_EN.
module tb_demux1to2048_wr_n;

    localparam int N = 32;

    logic          clk_i;
    logic          rst_ni;
    logic          wr_valid_i;
    logic          wr_ready_o;
    logic [10:0]   wr_addr_i;
    logic [N-1:0]  wr_data_i;
`ifdef DEMUX_BE_EN
    logic [N/8-1:0] wr_be_i;
`endif
    logic          clr_i;
    logic          busy_o;
    logic [N-1:0]  data_o [0:2047];
    logic [1:0]    dbg_state_o;

    int errors = 0;
    int checks = 0;

    logic [N-1:0]  model [0:2047];
    logic [11+N-1:0] exp_q[$];

    demux1to2048_wr_n #(.n(N), .address(11)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .wr_valid_i  (wr_valid_i),
        .wr_ready_o  (wr_ready_o),
        .wr_addr_i   (wr_addr_i),
        .wr_data_i   (wr_data_i),
`ifdef DEMUX_BE_EN
        .wr_be_i     (wr_be_i),
`endif
        .clr_i       (clr_i),
        .busy_o      (busy_o),
        .data_o      (data_o),
        .dbg_state_o (dbg_state_o)
    );

    // ---------------- clock / reset ----------------
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- check helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Whole-array compare; entries whose low 10 address bits are below
    // zero_below are expected to be zero (partially completed sweep).
    task automatic compare_all(input string name, input int zero_below);
        int bad = 0;
        int first = -1;
        logic [N-1:0] e;
        for (int i = 0; i < 2048; i++) begin
            e = ((i % 1024) < zero_below) ? '0 : model[i];
            if (data_o[i] !== e) begin
                if (first < 0) first = i;
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            e = ((first % 1024) < zero_below) ? '0 : model[first];
            $display("FAIL %s: %0d entries differ, entry %0d got %h want %h",
                     name, bad, first, data_o[first], e);
        end
    endtask

    task automatic zero_model();
        for (int i = 0; i < 2048; i++) model[i] = '0;
    endtask

    // ---------------- driver tasks (entered at posedge + 1) ----------------
    task automatic do_write(input logic [10:0] a, input logic [N-1:0] d, input logic [N/8-1:0] be);
        int waited = 0;
        logic [N-1:0] mask;
        wr_valid_i = 1'b1;
        wr_addr_i  = a;
        wr_data_i  = d;
`ifdef DEMUX_BE_EN
        wr_be_i    = be;
`endif
        @(negedge clk_i);
        while (!wr_ready_o && waited < 2000) begin
            waited++;
            @(negedge clk_i);
        end
        if (!wr_ready_o) begin
            checks++;
            errors++;
            $display("FAIL write_timeout: ready got 0 want 1 for addr %h", a);
        end else begin
`ifdef DEMUX_BE_EN
            for (int b = 0; b < N / 8; b++) mask[b*8 +: 8] = be[b] ? 8'hFF : 8'h00;
`else
            mask = '1;
            if (be == '0) mask = '1;
`endif
            model[a] = (model[a] & ~mask) | (d & mask);
            exp_q.push_back({a, model[a]});
        end
        @(posedge clk_i);
        #1;
        wr_valid_i = 1'b0;
    endtask

    task automatic idle_cycles(input int k);
        repeat (k) @(posedge clk_i);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int c = 0;
        @(negedge clk_i);
        while ((exp_q.size() != 0 || busy_o) && c < 200) begin
            c++;
            @(negedge clk_i);
        end
        if (c >= 200) begin
            checks++;
            errors++;
            $display("FAIL %s: still busy, pending %0d want 0", name, exp_q.size());
        end
        @(posedge clk_i);
        #1;
    endtask

    // Counts negedges with ready low, starting at the current negedge.
    task automatic count_ready_low(output int lowc);
        lowc = 0;
        while (!wr_ready_o && lowc < 3000) begin
            lowc++;
            @(negedge clk_i);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    logic hs_d1 = 1'b0;
    logic hs_d2 = 1'b0;
    always @(negedge clk_i) begin
        logic [11+N-1:0] item;
        if (!rst_ni) begin
            hs_d1 = 1'b0;
            hs_d2 = 1'b0;
        end else begin
            // A handshake seen before edge k is due on data_o after edge k+1.
            if (hs_d2) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard: got unexpected write want none queued");
                end else begin
                    item = exp_q.pop_front();
                    chk("write_data", 64'(data_o[item[11+N-1:N]]), 64'(item[N-1:0]));
                end
            end
            hs_d2 = hs_d1;
            hs_d1 = wr_valid_i && wr_ready_o;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int lowc;
        logic [10:0] a;
        logic [10:0] prev_a;

        rst_ni     = 1'b0;
        wr_valid_i = 1'b0;
        wr_addr_i  = '0;
        wr_data_i  = '0;
`ifdef DEMUX_BE_EN
        wr_be_i    = '1;
`endif
        clr_i      = 1'b0;
        zero_model();

        // Reset: low for 3 cycles.
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        @(negedge clk_i);
        compare_all("reset_storage", 0);
        chk("reset_ready", 64'(wr_ready_o), 64'd1);
        chk("reset_busy", 64'(busy_o), 64'd0);
        chk("reset_state", 64'(dbg_state_o), 64'd0);
        @(posedge clk_i);
        #1;

        // Single writes on consecutive cycles, across the group boundary.
        do_write(11'h7FF, 32'hDEADBEEF, '1);
        chk("busy_in_flight", 64'(busy_o), 64'd1);
        do_write(11'h000, 32'h12345678, '1);
        wait_idle("single_idle");
        chk("boundary_3ff", 64'(data_o[11'h3FF]), 64'd0);
        chk("boundary_400", 64'(data_o[11'h400]), 64'd0);
        chk("value_7ff", 64'(data_o[11'h7FF]), 64'hDEADBEEF);

        // Same-address collision: later write wins.
        do_write(11'h400, 32'h1, '1);
        do_write(11'h400, 32'h2, '1);
        wait_idle("collision_idle");
        chk("collision_final", 64'(data_o[11'h400]), 64'h2);

        // Randomised writes with gaps and occasional address reuse.
        prev_a = 11'h0;
        for (int i = 0; i < 300; i++) begin
            a = ($urandom_range(0, 7) == 0) ? prev_a : 11'($urandom_range(0, 2047));
            do_write(a, $urandom, N/8'($urandom));
            prev_a = a;
            if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
        end
        wait_idle("random_idle");
        compare_all("random_array", 0);

        // Clear while a write is pending: DRAIN then 1024 sweep cycles.
        do_write(11'd5, 32'hA5A5A5A5, '1);
        clr_i = 1'b1;
        @(negedge clk_i);
        chk("clr_blocks_ready", 64'(wr_ready_o), 64'd0);
        @(posedge clk_i);
        #1 clr_i = 1'b0;
        @(negedge clk_i);
        chk("drain_state", 64'(dbg_state_o), 64'd1);
        count_ready_low(lowc);
        chk("drain_clear_cycles", 64'(lowc), 64'd1025);
        zero_model();
        compare_all("cleared_array", 0);
        chk("clear_done_busy", 64'(busy_o), 64'd0);
        @(posedge clk_i);
        #1;

        // Refill some entries, then clear and write in the same cycle.
        for (int i = 0; i < 40; i++) do_write(11'($urandom_range(0, 2047)), $urandom, '1);
        do_write(11'h6A0, 32'hCAFEF00D, '1);
        wait_idle("refill_idle");
        wr_valid_i = 1'b1;
        wr_addr_i  = 11'h6A0;
        wr_data_i  = 32'h0BADBEEF;
        clr_i      = 1'b1;
        @(negedge clk_i);
        chk("clr_wins_ready", 64'(wr_ready_o), 64'd0);
        chk("clr_wins_entry", 64'(data_o[11'h6A0]), 64'hCAFEF00D);
        @(posedge clk_i);
        #1;
        wr_valid_i = 1'b0;
        clr_i      = 1'b0;
        @(negedge clk_i);
        chk("clear_state", 64'(dbg_state_o), 64'd2);
        clr_i = 1'b1;  // ignored while clearing
        repeat (500) @(posedge clk_i);
        #1;
        clr_i = 1'b0;
        compare_all("partial_clear_500", 500);
        chk("partial_ready", 64'(wr_ready_o), 64'd0);

        // Reset mid-clear.
        rst_ni = 1'b0;
        #1;
        chk("midreset_state", 64'(dbg_state_o), 64'd0);
        chk("midreset_busy", 64'(busy_o), 64'd0);
        zero_model();
        compare_all("midreset_storage", 0);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        @(negedge clk_i);
        chk("post_reset_ready", 64'(wr_ready_o), 64'd1);
        @(posedge clk_i);
        #1;

`ifdef DEMUX_BE_EN
        do_write(11'd9, 32'hFFFFFFFF, 4'hF);
        do_write(11'd9, 32'h00000000, 4'b0101);
        wait_idle("be_idle");
        chk("be_merge", 64'(data_o[9]), 64'hFF00FF00);
`endif

        // Post-reset write still works.
        do_write(11'h3FF, 32'h0F0F1234, '1);
        wait_idle("final_idle");
        compare_all("final_array", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/demux1to2048_wr_n.md
# demux1to2048_wr_n

Write-side counterpart of the 2048:1 read mux. It accepts a single write (address, data) through a valid/ready handshake and decodes the address in two stages: group select on the top bit, then 1024-way within the group. The write lands in one of 2048 n-bit storage entries. All entries are exposed on `data_o`, which feeds the 2048:1 read mux directly. A sequential bulk-clear engine zeroes the whole array on request.

## Interface
Parameters:
- `n`, 32, data width per entry
- `address`, 11, address width (fixed; 2048 entries)

Ports:
- `clk_i`, in, 1, clock; all state updates on the rising edge
- `rst_ni`, in, 1, reset; **asynchronous, active-low**
- `wr_valid_i`, in, 1, write request
- `wr_ready_o`, out, 1, write accepted when `wr_valid_i && wr_ready_o`
- `wr_addr_i`, in, 11, target entry
- `wr_data_i`, in, n, write data
- `clr_i`, in, 1, bulk-clear request (single-cycle pulse or level)
- `busy_o`, out, 1, high while a write is in flight or a clear is running
- `data_o`, out, n × [0:2047], storage contents

## Operation
- **Stage 1 (accept):** on handshake, register `addr`, `data` and `s1_valid`.
- **Stage 2 (write):** `s1_addr[10]` selects the group and `s1_addr[9:0]` selects the one-hot entry. The entry is written on the next edge and `s1_valid` clears unless a new write was accepted.
- **Throughput:** back-to-back writes at one per cycle. Two consecutive writes to the same address: the later one wins.
- **Ready:** `wr_ready_o = (state==IDLE) && !clr_i`. It never depends on `wr_valid_i`.
- **FSM states:**
  - `IDLE` → `DRAIN` when `clr_i` is seen and a stage-1 write is pending.
  - `IDLE` → `CLEAR` when `clr_i` is seen and no write is pending.
  - `DRAIN` → `CLEAR` after one cycle; the pending write completes first.
  - `CLEAR`: a 10-bit counter `idx` runs 0..1023. Each cycle it zeroes entry `idx` in both groups in parallel.
  - `CLEAR` → `IDLE` after `idx==1023`.
- **Clear edge cases:**
  - `clr_i` asserted during `DRAIN`/`CLEAR` is ignored; no restart.
  - `clr_i` and `wr_valid_i` in the same cycle: clear wins and the write is not accepted.
- **busy_o:** `s1_valid || state!=IDLE`.
- **Width rule:** data is stored unmodified; there is no sign or zero extension.

## Timing
- **Reset values:** all `data_o` entries = 0, `wr_ready_o` = 1 once `rst_ni` deasserts, `busy_o` = 0, state `IDLE`, `s1_valid` = 0, `idx` = 0.
- **Write latency:** a handshake at edge k makes `data_o[addr]` show the new value after edge k+1.
- **Clear duration:** 1024 cycles in `CLEAR`, plus 1 in `DRAIN` if a write was pending. `wr_ready_o` returns high the cycle after the edge on which `idx==1023` is written.
- **Reset mid-operation:** asserting `rst_ni` low during a write or a clear immediately zeroes storage, discards the pending write and returns to `IDLE`.

## Configuration
Macro: `DEMUX_BE_EN`
- **Defined:** adds port `wr_be_i` (in, n/8), which is registered with the data in stage 1. Only the bytes with their enable set are updated. n must be a multiple of 8; elaboration error otherwise. Clear ignores byte enables and zeroes every byte.
- **Undefined:** there is no `wr_be_i` port and every write updates the full entry.

## Structure
- **Package `demux_pkg`:**
  - constants `ADDR_W=11`, `GR=2`, `M=1024`, `S=1`
  - state enum `{IDLE, DRAIN, CLEAR}`
  - stage-1 packed struct (`valid`, `addr`, `data`, plus `be` under the macro)
- **Sub-module `demux1024_wr_n`:** a 1024-entry bank with one-hot decode, write enable, data and per-bank clear index. It is instantiated `GR` times in a generate loop. Its outputs are concatenated into `data_o` as `data_o[g*M+j]`.

## Test plan
- **Reset:** hold `rst_ni` low 3 cycles, release → all 2048 `data_o` = 0, `wr_ready_o`=1, `busy_o`=0.
- **Single writes:** write 0xDEADBEEF to addr 0x7FF, then 0x12345678 to addr 0x000 on consecutive cycles → each value appears one cycle after its handshake edge. Entries 0x3FF and 0x400 stay 0, which checks the group boundary.
- **Same-address collision:** back-to-back writes to addr 0x400 with 0x1 then 0x2 → final value 0x2.
- **Clear while a write is pending:** write 0xA5A5A5A5 to addr 5 and pulse `clr_i` the next cycle → FSM passes through `DRAIN`. Then 1024 cycles with `wr_ready_o`=0, after which all entries = 0.
- **Simultaneous clear and write:** `clr_i` and `wr_valid_i` high together → no handshake and the entry is unchanged before the clear. Reset asserted at `idx`=500 → immediate `IDLE` and all-zero storage.
- **With `DEMUX_BE_EN`:** preload 0xFFFFFFFF at addr 9, then write 0x00000000 with `wr_be_i`=4'b0101 → result 0xFF00FF00.
